// File: rtl/sea_battle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sea_battle_pkg
// Description : Shared constants for the sea-battle front end. Holds the
//               PS/2 scan-code set 2 values the cursor controller reacts to,
//               the ship length used for placement clamping, and the
//               make-code decoder state encoding.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package sea_battle_pkg;

    // Sequence prefixes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Extended (E0-prefixed) arrow keys
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Plain WASD keys
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    // Action keys
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Length of the ship being placed, in cells
    localparam int SHIP_LEN = 4;

    // Make-code decoder states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

endpackage
`default_nettype wire

// File: rtl/ps2_make_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_make_decoder
// Description : Tracks PS/2 set-2 make / break / E0-extended sequences and
//               turns completed make codes into single-cycle action pulses.
//               Pulses are decoded from the current state and the incoming
//               byte so the consumer can update in the very next cycle.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module ps2_make_decoder
    import sea_battle_pkg::*;
(
    input  logic       clk,
    input  logic       sys_nrst,
    input  logic [7:0] key_code_i,
    input  logic       key_valid_i,
    output logic       move_up_o,
    output logic       move_down_o,
    output logic       move_left_o,
    output logic       move_right_o,
    output logic       fire_req_o,
    output logic       rotate_req_o
);

    dec_state_e state_q;

    logic make_plain;
    logic make_ext;

    // Sequence tracker: prefixes steer the state, everything else returns to IDLE
    always_ff @(posedge clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state_q <= ST_IDLE;
        end else if (key_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (key_code_i == SC_EXT) begin
                        state_q <= ST_EXT;
                    end else if (key_code_i == SC_BRK) begin
                        state_q <= ST_BRK;
                    end
                end
                ST_EXT: begin
                    state_q <= (key_code_i == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: begin
                    // Byte following a break prefix is released key; swallow it
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A make code completes on a non-prefix byte in IDLE (plain) or EXT (extended)
    always_comb begin
        make_plain   = key_valid_i && (state_q == ST_IDLE)
                       && (key_code_i != SC_EXT) && (key_code_i != SC_BRK);
        make_ext     = key_valid_i && (state_q == ST_EXT) && (key_code_i != SC_BRK);

        move_up_o    = (make_ext && key_code_i == SC_UP)    || (make_plain && key_code_i == SC_W);
        move_down_o  = (make_ext && key_code_i == SC_DOWN)  || (make_plain && key_code_i == SC_S);
        move_left_o  = (make_ext && key_code_i == SC_LEFT)  || (make_plain && key_code_i == SC_A);
        move_right_o = (make_ext && key_code_i == SC_RIGHT) || (make_plain && key_code_i == SC_D);
        fire_req_o   = make_plain && (key_code_i == SC_ENTER);
        rotate_req_o = make_plain && (key_code_i == SC_SPACE);
    end

endmodule
`default_nettype wire

// File: rtl/grid_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : grid_cursor_ctrl
// Description : Cursor controller between the PS/2 byte receiver and the VGA
//               renderer. Moves a cell cursor over a GRID_W x GRID_H board
//               (clamp or wrap at the edges), derives the registered pixel
//               position, and raises a valid/ready fire request on Enter.
//               Optional feature macro GRID_CURSOR_ORIENT_EN: adds the orient
//               output, Space toggles it, and the cursor is kept where a
//               SHIP_LEN ship fits in the current orientation.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module grid_cursor_ctrl
    import sea_battle_pkg::*;
#(
    parameter  int GRID_W   = 10,
    parameter  int GRID_H   = 10,
    parameter  int CELL_PX  = 32,
    parameter  int ORIGIN_X = 160,
    parameter  int ORIGIN_Y = 80,
    parameter  int WRAP     = 0,
    localparam int CXW      = $clog2(GRID_W),
    localparam int CYW      = $clog2(GRID_H)
)
(
    input  logic           clk,
    input  logic           sys_nrst,
    input  logic [7:0]     key_code,
    input  logic           key_valid,
    output logic [CXW-1:0] cell_x,
    output logic [CYW-1:0] cell_y,
    output logic [9:0]     cursor_x,
    output logic [9:0]     cursor_y,
    output logic           fire_valid,
    output logic [CXW-1:0] fire_x,
    output logic [CYW-1:0] fire_y,
`ifdef GRID_CURSOR_ORIENT_EN
    output logic           orient,
`endif
    input  logic           fire_ready
);

    localparam logic [CXW-1:0] X_ONE      = CXW'(1);
    localparam logic [CYW-1:0] Y_ONE      = CYW'(1);
    localparam logic [CXW-1:0] X_MAX_FULL = CXW'(GRID_W - 1);
    localparam logic [CYW-1:0] Y_MAX_FULL = CYW'(GRID_H - 1);
`ifdef GRID_CURSOR_ORIENT_EN
    localparam logic [CXW-1:0] X_MAX_SHIP = CXW'(GRID_W - SHIP_LEN);
    localparam logic [CYW-1:0] Y_MAX_SHIP = CYW'(GRID_H - SHIP_LEN);
`endif

    logic move_up, move_down, move_left, move_right;
    logic fire_req, rotate_req;

    logic [CXW-1:0] cell_x_q, cell_x_d;
    logic [CYW-1:0] cell_y_q, cell_y_d;
    logic [CXW-1:0] x_max;
    logic [CYW-1:0] y_max;
    logic [9:0]     cursor_x_q, cursor_y_q;
    logic           fire_valid_q;
    logic [CXW-1:0] fire_x_q;
    logic [CYW-1:0] fire_y_q;

    ps2_make_decoder u_decoder (
        .clk          (clk),
        .sys_nrst     (sys_nrst),
        .key_code_i   (key_code),
        .key_valid_i  (key_valid),
        .move_up_o    (move_up),
        .move_down_o  (move_down),
        .move_left_o  (move_left),
        .move_right_o (move_right),
        .fire_req_o   (fire_req),
        .rotate_req_o (rotate_req)
    );

`ifdef GRID_CURSOR_ORIENT_EN
    logic orient_q;

    // Space flips the ship orientation
    always_ff @(posedge clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            orient_q <= 1'b0;
        end else if (rotate_req) begin
            orient_q <= ~orient_q;
        end
    end

    assign orient = orient_q;

    // Reachable limits shrink along the ship axis so the whole ship fits
    always_comb begin
        x_max = X_MAX_FULL;
        y_max = Y_MAX_FULL;
        if (!orient_q) begin
            x_max = X_MAX_SHIP;
        end else begin
            y_max = Y_MAX_SHIP;
        end
    end
`else
    logic unused_rotate;
    assign unused_rotate = rotate_req;

    // Whole grid reachable
    always_comb begin
        x_max = X_MAX_FULL;
        y_max = Y_MAX_FULL;
    end
`endif

    // Next cell: pull back inside a shrunk limit first, else apply a move with
    // explicit limit compares (GRID_W/H need not be powers of two)
    always_comb begin
        cell_x_d = cell_x_q;
        cell_y_d = cell_y_q;

        if (cell_x_q > x_max) begin
            cell_x_d = x_max;
        end else if (move_left) begin
            if (cell_x_q == '0) begin
                if (WRAP != 0) cell_x_d = x_max;
            end else begin
                cell_x_d = cell_x_q - X_ONE;
            end
        end else if (move_right) begin
            if (cell_x_q >= x_max) begin
                if (WRAP != 0) cell_x_d = '0;
            end else begin
                cell_x_d = cell_x_q + X_ONE;
            end
        end

        if (cell_y_q > y_max) begin
            cell_y_d = y_max;
        end else if (move_up) begin
            if (cell_y_q == '0) begin
                if (WRAP != 0) cell_y_d = y_max;
            end else begin
                cell_y_d = cell_y_q - Y_ONE;
            end
        end else if (move_down) begin
            if (cell_y_q >= y_max) begin
                if (WRAP != 0) cell_y_d = '0;
            end else begin
                cell_y_d = cell_y_q + Y_ONE;
            end
        end
    end

    // Cell registers
    always_ff @(posedge clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            cell_x_q <= '0;
            cell_y_q <= '0;
        end else begin
            cell_x_q <= cell_x_d;
            cell_y_q <= cell_y_d;
        end
    end

    // Pixel position trails the cell by one cycle; 10-bit truncation is intended
    always_ff @(posedge clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            cursor_x_q <= 10'(ORIGIN_X);
            cursor_y_q <= 10'(ORIGIN_Y);
        end else begin
            cursor_x_q <= 10'(ORIGIN_X + int'(cell_x_q) * CELL_PX);
            cursor_y_q <= 10'(ORIGIN_Y + int'(cell_y_q) * CELL_PX);
        end
    end

    // Fire request: latch the cell on Enter, hold until accepted; Enter while
    // pending (including the accept cycle) is dropped
    always_ff @(posedge clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            fire_valid_q <= 1'b0;
            fire_x_q     <= '0;
            fire_y_q     <= '0;
        end else if (fire_valid_q) begin
            if (fire_ready) begin
                fire_valid_q <= 1'b0;
            end
        end else if (fire_req) begin
            fire_valid_q <= 1'b1;
            fire_x_q     <= cell_x_q;
            fire_y_q     <= cell_y_q;
        end
    end

    assign cell_x     = cell_x_q;
    assign cell_y     = cell_y_q;
    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
    assign fire_valid = fire_valid_q;
    assign fire_x     = fire_x_q;
    assign fire_y     = fire_y_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_cursor_ctrl
// Description : Scoreboard bench for grid_cursor_ctrl. Two instances share
//               the key stream: dut (clamp) and dut_w (wrap). Stimulus pushes
//               expected snapshots and fire transactions into queues; a
//               negedge monitor pops and compares them.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module tb_grid_cursor_ctrl;

    logic       clk = 1'b0;
    logic       sys_nrst = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_valid = 1'b0;
    logic       fire_ready = 1'b0;
    logic       fire_ready_w = 1'b1;

    logic [3:0] cell_x, cell_y, fire_x, fire_y;
    logic [9:0] cursor_x, cursor_y;
    logic       fire_valid;
    logic [3:0] w_cell_x, w_cell_y, w_fire_x, w_fire_y;
    logic [9:0] w_cursor_x, w_cursor_y;
    logic       w_fire_valid;
`ifdef GRID_CURSOR_ORIENT_EN
    logic       orient, w_orient;
`endif

    always #5 clk = ~clk;

    grid_cursor_ctrl #(.WRAP(0)) dut (
        .clk(clk), .sys_nrst(sys_nrst), .key_code(key_code), .key_valid(key_valid),
        .cell_x(cell_x), .cell_y(cell_y), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .fire_valid(fire_valid), .fire_x(fire_x), .fire_y(fire_y),
`ifdef GRID_CURSOR_ORIENT_EN
        .orient(orient),
`endif
        .fire_ready(fire_ready)
    );

    grid_cursor_ctrl #(.WRAP(1)) dut_w (
        .clk(clk), .sys_nrst(sys_nrst), .key_code(key_code), .key_valid(key_valid),
        .cell_x(w_cell_x), .cell_y(w_cell_y), .cursor_x(w_cursor_x), .cursor_y(w_cursor_y),
        .fire_valid(w_fire_valid), .fire_x(w_fire_x), .fire_y(w_fire_y),
`ifdef GRID_CURSOR_ORIENT_EN
        .orient(w_orient),
`endif
        .fire_ready(fire_ready_w)
    );

    typedef struct {
        int due;
        int cx, cy, px, py;
        int fv, fchk, fx, fy;
        int wx, wy, ori;
    } exp_t;

    typedef struct {
        int fx, fy;
    } fire_t;

    exp_t  sq[$];
    fire_t fq[$];
    exp_t  me;
    fire_t mf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected settled state (hand-tracked by the stimulus)
    int ex = 0, ey = 0, wx = 0, wy = 0;
    int efv = 0, efchk = 1, efx = 0, efy = 0, eori = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare due snapshots and every accepted fire transaction
    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            me = sq.pop_front();
            cmp("cell_x",     int'(cell_x),     me.cx);
            cmp("cell_y",     int'(cell_y),     me.cy);
            cmp("cursor_x",   int'(cursor_x),   me.px);
            cmp("cursor_y",   int'(cursor_y),   me.py);
            cmp("fire_valid", int'(fire_valid), me.fv);
            if (me.fchk != 0) begin
                cmp("fire_x_held", int'(fire_x), me.fx);
                cmp("fire_y_held", int'(fire_y), me.fy);
            end
            cmp("wrap_cell_x", int'(w_cell_x), me.wx);
            cmp("wrap_cell_y", int'(w_cell_y), me.wy);
`ifdef GRID_CURSOR_ORIENT_EN
            cmp("orient", int'(orient), me.ori);
`endif
        end
        if (fire_valid && fire_ready) begin
            if (fq.size() == 0) begin
                cmp("fire_unexpected", 1, 0);
            end else begin
                mf = fq.pop_front();
                cmp("fire_x", int'(fire_x), mf.fx);
                cmp("fire_y", int'(fire_y), mf.fy);
            end
        end
    end

    task automatic push(input int lag, input int px, input int py);
        exp_t e;
        e.due = cyc + lag;
        e.cx = ex;  e.cy = ey;  e.px = px;  e.py = py;
        e.fv = efv; e.fchk = efchk; e.fx = efx; e.fy = efy;
        e.wx = wx;  e.wy = wy;  e.ori = eori;
        sq.push_back(e);
    endtask

    // Settled snapshot: pixel = origin + cell * 32
    task automatic chk();
        push(0, 160 + 32 * ex, 80 + 32 * ey);
    endtask

    task automatic push_fire(input int x, input int y);
        fire_t f;
        f.fx = x;
        f.fy = y;
        fq.push_back(f);
    endtask

    task automatic send(input logic [7:0] b);
        key_code  = b;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 sys_nrst = 1'b1;
        settle();
        chk();                                        // reset state

        // Right x3 (extended); latency: cell now, pixel one cycle later
        for (int i = 0; i < 3; i++) begin
            send(8'hE0); send(8'h74);
        end
        ex = 3; wx = 3;
        push(0, 224, 80);
        @(posedge clk); #1;
        push(0, 256, 80);
        settle();

        // A x3 back to the left edge, then one more: clamp vs wrap
        for (int i = 0; i < 3; i++) send(8'h1C);
        ex = 0; wx = 0;
        settle(); chk();
        send(8'h1C);
        ex = 0; wx = 9;
        settle(); chk();
        send(8'h23);                                  // D
        ex = 1; wx = 0;
        settle(); chk();
        send(8'h1D);                                  // W at top edge
        ey = 0; wy = 9;
        settle(); chk();
        send(8'h1B); send(8'h1B);                     // S x2
        ey = 2; wy = 1;
        settle(); chk();

        // Break sequences change nothing; a following W is a fresh make
        send(8'hF0); send(8'h1D);
        send(8'hE0); send(8'hF0); send(8'h75);
        settle(); chk();
        send(8'h1D);
        ey = 1; wy = 0;
        settle(); chk();

        // Move to (4,7) using extended Down/Left and plain D
        for (int i = 0; i < 6; i++) begin
            send(8'hE0); send(8'h72);
        end
        for (int i = 0; i < 4; i++) send(8'h23);
        send(8'hE0); send(8'h6B);
        ex = 4; ey = 7; wx = 3; wy = 6;
        settle(); chk();

        // Fire at (4,7), held for 5 cycles with fire_ready low
        send(8'h5A);
        efv = 1; efchk = 1; efx = 4; efy = 7;
        push_fire(4, 7);
        for (int i = 0; i < 5; i++) begin
            chk();
            @(posedge clk); #1;
        end
        // Move and a second Enter while pending
        send(8'hE0); send(8'h74);
        send(8'h5A);
        ex = 5; wx = 4;
        settle(); chk();
        // Accept, with an Enter on the accept cycle itself
        fire_ready = 1'b1;
        send(8'h5A);
        fire_ready = 1'b0;
        efv = 0; efchk = 0;
        chk();
        settle(); chk();

        // Fire at (5,7), accepted immediately
        send(8'h5A);
        push_fire(5, 7);
        fire_ready = 1'b1;
        @(posedge clk); #1;
        fire_ready = 1'b0;
        settle(); chk();

        // Reset after E0 with a fire pending: all cleared, 74 then plain
        send(8'h5A);
        send(8'hE0);
        sys_nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1 sys_nrst = 1'b1;
        ex = 0; ey = 0; wx = 0; wy = 0;
        efv = 0; efchk = 1; efx = 0; efy = 0;
        fire_ready = 1'b1;
        settle(); chk();
        send(8'h74);
        settle(); chk();
        send(8'hE0); send(8'h74);
        ex = 1; wx = 1; efchk = 0;
        settle(); chk();

`ifdef GRID_CURSOR_ORIENT_EN
        // Horizontal ship: x limited to 6; wrap uses that limit
        for (int i = 0; i < 5; i++) send(8'h23);
        for (int i = 0; i < 3; i++) begin
            send(8'hE0); send(8'h74);
        end
        ex = 6; wx = 2;
        settle(); chk();
        for (int i = 0; i < 8; i++) send(8'h1B);
        ey = 8; wy = 8;
        settle(); chk();
        send(8'h29);                                  // Space -> vertical, y re-clamps
        eori = 1; ey = 6; wy = 6;
        settle(); chk();
`endif

        settle();
        cmp("snapshots_drained", sq.size(), 0);
        cmp("fires_drained",     fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
